// File: rtl/beat_scheduler_if.sv
// ============================================================================
//  Module   : beat_scheduler_if
//  Purpose  : Signal bundle between the beat scheduler and its surroundings:
//             game controls (start/pause), the chart ROM port, the arrow
//             collision checker link and the stats/status read by the display.
//  Ports    : master modport = scheduler side, slave modport = environment.
//             lives exists only when BEAT_SCHED_LIVES_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface beat_scheduler_if #(
    parameter int CHART_AW = 5
);
    logic                start;
    logic                pause;
    logic [CHART_AW-1:0] chart_addr;
    logic [3:0]          chart_data;
    logic                correctHit;
    logic                incorrectHit;
    logic [3:0]          arrow;
    logic                metronome_clk;
    logic [15:0]         score;
    logic [7:0]          combo;
    logic [7:0]          max_combo;
    logic [7:0]          misses;
    logic                done;
    logic [2:0]          state;
`ifdef BEAT_SCHED_LIVES_EN
    logic [3:0]          lives;

    modport master (
        input  start, pause, chart_data, correctHit, incorrectHit,
        output chart_addr, arrow, metronome_clk, score, combo, max_combo,
               misses, done, state, lives
    );

    modport slave (
        output start, pause, chart_data, correctHit, incorrectHit,
        input  chart_addr, arrow, metronome_clk, score, combo, max_combo,
               misses, done, state, lives
    );
`else
    modport master (
        input  start, pause, chart_data, correctHit, incorrectHit,
        output chart_addr, arrow, metronome_clk, score, combo, max_combo,
               misses, done, state
    );

    modport slave (
        output start, pause, chart_data, correctHit, incorrectHit,
        input  chart_addr, arrow, metronome_clk, score, combo, max_combo,
               misses, done, state
    );
`endif
endinterface

`default_nettype wire

// File: rtl/beat_scheduler.sv
// ============================================================================
//  Module   : beat_scheduler
//  Purpose  : Plays one pass through a step chart. Each beat fetches an arrow
//             code from a synchronous ROM, presents it with a hit window
//             (metronome_clk) to the collision checker, then grades the
//             checker's verdict at the end of the beat and updates the stats.
//  Ports    : clk, rst (asynchronous, active high)
//             bus (beat_scheduler_if.master): start, pause, chart_addr,
//             chart_data, correctHit, incorrectHit, arrow, metronome_clk,
//             score, combo, max_combo, misses, done, state [, lives]
//  Options  : BEAT_SCHED_LIVES_EN - adds LIVES parameter and lives output;
//             the game ends early when the last life is lost.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module beat_scheduler #(
    parameter int BEAT_TICKS   = 50000000,
    parameter int WINDOW_TICKS = 12500000,
    parameter int CHART_LEN    = 32,
    parameter int CHART_AW     = 5
`ifdef BEAT_SCHED_LIVES_EN
    ,
    parameter int LIVES        = 3
`endif
) (
    input  wire logic         clk,
    input  wire logic         rst,
    beat_scheduler_if.master  bus
);

    localparam int                  c_tick_w     = $clog2(BEAT_TICKS);
    localparam logic [c_tick_w-1:0] c_tick_last  = c_tick_w'(BEAT_TICKS - 1);
    localparam logic [c_tick_w-1:0] c_window     = c_tick_w'(WINDOW_TICKS);
    localparam logic [CHART_AW-1:0] c_index_last = CHART_AW'(CHART_LEN - 1);
    localparam logic [3:0]          c_arrow_none = 4'd0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_BEAT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state,     w_state;
    logic [CHART_AW-1:0] r_index,     w_index;
    logic [c_tick_w-1:0] r_tick,      w_tick;
    logic [3:0]          r_arrow,     w_arrow;
    logic                r_metro,     w_metro;
    logic [15:0]         r_score,     w_score;
    logic [7:0]          r_combo,     w_combo;
    logic [7:0]          r_max_combo, w_max_combo;
    logic [7:0]          r_misses,    w_misses;
    logic                r_done,      w_done;
`ifdef BEAT_SCHED_LIVES_EN
    logic [3:0]          r_lives,     w_lives;
`endif

    // Grading of the beat currently on the checker's inputs.
    logic                w_hit;
    logic                w_miss;
    logic                w_game_over;
    logic [c_tick_w-1:0] w_tick_inc;
    logic [15:0]         w_points;
    logic [16:0]         w_score_sum;
    logic [7:0]          w_combo_inc;

    assign w_hit      = (r_arrow != c_arrow_none) && bus.correctHit && !bus.incorrectHit;
    // A blank beat only counts against the player for a wrong press.
    assign w_miss     = (r_arrow != c_arrow_none) ? !w_hit : bus.incorrectHit;
    assign w_tick_inc = r_tick + 1'b1;
    assign w_points   = (r_combo >= 8'd8) ? 16'd15 : 16'd10;
    assign w_score_sum = {1'b0, r_score} + {1'b0, w_points};
    assign w_combo_inc = (r_combo == 8'hFF) ? r_combo : r_combo + 8'd1;

`ifdef BEAT_SCHED_LIVES_EN
    assign w_game_over = (r_index == c_index_last) || (w_miss && (r_lives <= 4'd1));
`else
    assign w_game_over = (r_index == c_index_last);
`endif

    always_comb begin
        w_state     = r_state;
        w_index     = r_index;
        w_tick      = r_tick;
        w_arrow     = r_arrow;
        w_metro     = r_metro;
        w_score     = r_score;
        w_combo     = r_combo;
        w_max_combo = r_max_combo;
        w_misses    = r_misses;
        w_done      = r_done;
`ifdef BEAT_SCHED_LIVES_EN
        w_lives     = r_lives;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_score     = '0;
                    w_combo     = '0;
                    w_max_combo = '0;
                    w_misses    = '0;
                    w_index     = '0;
                    w_done      = 1'b0;
`ifdef BEAT_SCHED_LIVES_EN
                    w_lives     = 4'(LIVES);
`endif
                    w_state     = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state = S_LATCH;
            end
            S_LATCH: begin
                w_arrow = bus.chart_data;
                w_tick  = '0;
                // Tick 0 is always inside the window since WINDOW_TICKS >= 1.
                w_metro = 1'b1;
                w_state = S_BEAT;
            end
            S_BEAT: begin
                if (!bus.pause) begin
                    if (r_tick == c_tick_last) begin
                        w_metro = 1'b0;
                        if (w_hit) begin
                            w_score     = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
                            w_combo     = w_combo_inc;
                            w_max_combo = (w_combo_inc > r_max_combo) ? w_combo_inc : r_max_combo;
                        end
                        if (w_miss) begin
                            w_combo  = '0;
                            w_misses = (r_misses == 8'hFF) ? r_misses : r_misses + 8'd1;
`ifdef BEAT_SCHED_LIVES_EN
                            w_lives  = (r_lives == 4'd0) ? r_lives : r_lives - 4'd1;
`endif
                        end
                        if (w_game_over) begin
                            w_arrow = c_arrow_none;
                            w_done  = 1'b1;
                            w_state = S_DONE;
                        end else begin
                            w_index = r_index + 1'b1;
                            w_state = S_FETCH;
                        end
                    end else begin
                        w_tick  = w_tick_inc;
                        // Registered look-ahead keeps metronome_clk glitch-free.
                        w_metro = (w_tick_inc < c_window);
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_index     <= '0;
            r_tick      <= '0;
            r_arrow     <= '0;
            r_metro     <= 1'b0;
            r_score     <= '0;
            r_combo     <= '0;
            r_max_combo <= '0;
            r_misses    <= '0;
            r_done      <= 1'b0;
`ifdef BEAT_SCHED_LIVES_EN
            r_lives     <= 4'(LIVES);
`endif
        end else begin
            r_state     <= w_state;
            r_index     <= w_index;
            r_tick      <= w_tick;
            r_arrow     <= w_arrow;
            r_metro     <= w_metro;
            r_score     <= w_score;
            r_combo     <= w_combo;
            r_max_combo <= w_max_combo;
            r_misses    <= w_misses;
            r_done      <= w_done;
`ifdef BEAT_SCHED_LIVES_EN
            r_lives     <= w_lives;
`endif
        end
    end

    assign bus.chart_addr    = r_index;
    assign bus.arrow         = r_arrow;
    assign bus.metronome_clk = r_metro;
    assign bus.score         = r_score;
    assign bus.combo         = r_combo;
    assign bus.max_combo     = r_max_combo;
    assign bus.misses        = r_misses;
    assign bus.done          = r_done;
    assign bus.state         = r_state;
`ifdef BEAT_SCHED_LIVES_EN
    assign bus.lives         = r_lives;
`endif

endmodule

`default_nettype wire

// File: tb/tb_beat_scheduler.sv
// ============================================================================
//  Module   : tb_beat_scheduler
//  Purpose  : Self-checking bench for beat_scheduler. A beat-level reference
//             model predicts the outputs each cycle; directed scenarios pin
//             literal results and random play exercises the rest. A second
//             short-beat instance plays a long all-hit chart for the combo
//             bonus.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_beat_scheduler;

    localparam int BT = 8;
    localparam int WT = 4;
    localparam int CL = 4;
    localparam int AW = 2;
`ifdef BEAT_SCHED_LIVES_EN
    localparam int LV = 2;
`else
    localparam int LV = 0;
`endif
    localparam int P_IDLE = 0, P_FETCH = 1, P_LATCH = 2, P_BEAT = 3, P_DONE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    beat_scheduler_if #(.CHART_AW(AW)) bus ();
    beat_scheduler_if #(.CHART_AW(4))  bus2 ();

`ifdef BEAT_SCHED_LIVES_EN
    beat_scheduler #(.BEAT_TICKS(BT), .WINDOW_TICKS(WT), .CHART_LEN(CL),
                     .CHART_AW(AW), .LIVES(LV))
        dut (.clk(clk), .rst(rst), .bus(bus.master));
`else
    beat_scheduler #(.BEAT_TICKS(BT), .WINDOW_TICKS(WT), .CHART_LEN(CL),
                     .CHART_AW(AW))
        dut (.clk(clk), .rst(rst), .bus(bus.master));
`endif

    beat_scheduler #(.BEAT_TICKS(2), .WINDOW_TICKS(1), .CHART_LEN(12), .CHART_AW(4))
        dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

    logic [3:0] chart [CL] = '{4'd1, 4'd2, 4'd0, 4'd4};

    always @(posedge clk) bus.chart_data <= chart[bus.chart_addr];
    always @(posedge clk) bus2.chart_data <= {2'b00, bus2.chart_addr[1:0]} + 4'd1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_phase, m_idx, m_tick, m_arrow, m_score, m_combo, m_max, m_miss, m_lives;

    task automatic m_reset();
        m_phase = P_IDLE; m_idx = 0; m_tick = 0; m_arrow = 0;
        m_score = 0; m_combo = 0; m_max = 0; m_miss = 0; m_lives = LV;
    endtask

    task automatic m_step();
        bit hit, miss, over;
        case (m_phase)
            P_IDLE, P_DONE: if (bus.start) begin
                m_score = 0; m_combo = 0; m_max = 0; m_miss = 0;
                m_idx = 0; m_lives = LV; m_phase = P_FETCH;
            end
            P_FETCH: m_phase = P_LATCH;
            P_LATCH: begin m_arrow = chart[m_idx]; m_tick = 0; m_phase = P_BEAT; end
            default: if (!bus.pause) begin
                if (m_tick < BT - 1) m_tick++;
                else begin
                    hit  = (m_arrow != 0) && bus.correctHit && !bus.incorrectHit;
                    miss = (m_arrow != 0) ? !hit : bus.incorrectHit;
                    if (hit) begin
                        m_score = m_score + ((m_combo >= 8) ? 15 : 10);
                        if (m_score > 65535) m_score = 65535;
                        if (m_combo < 255) m_combo++;
                        if (m_combo > m_max) m_max = m_combo;
                    end
                    if (miss) begin
                        m_combo = 0;
                        if (m_miss < 255) m_miss++;
                        m_lives--;
                    end
                    over = (m_idx == CL - 1);
`ifdef BEAT_SCHED_LIVES_EN
                    if (miss && m_lives == 0) over = 1;
`endif
                    if (over) begin m_phase = P_DONE; m_arrow = 0; end
                    else begin m_idx++; m_phase = P_FETCH; end
                end
            end
        endcase
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                chk("state", int'(bus.state), m_phase);
                chk("done", int'(bus.done), int'(m_phase == P_DONE));
                chk("metronome", int'(bus.metronome_clk),
                    int'(m_phase == P_BEAT && m_tick < WT));
                chk("score", int'(bus.score), m_score);
                chk("combo", int'(bus.combo), m_combo);
                chk("max_combo", int'(bus.max_combo), m_max);
                chk("misses", int'(bus.misses), m_miss);
                if (m_phase == P_IDLE || m_phase == P_BEAT || m_phase == P_DONE)
                    chk("arrow", int'(bus.arrow), m_arrow);
                if (m_phase == P_FETCH || m_phase == P_LATCH || m_phase == P_BEAT)
                    chk("chart_addr", int'(bus.chart_addr), m_idx);
`ifdef BEAT_SCHED_LIVES_EN
                chk("lives", int'(bus.lives), m_lives);
`endif
            end
        end
    end

    // ---------------- input driver (applies controls on falling edges) -------
    int         mode    = 0;     // 0 static, 1 per-beat table, 2 random
    logic       s_start = 1'b0;
    logic       s_pause = 1'b0;
    logic       s_ch    = 1'b0;
    logic       s_ih    = 1'b0;
    logic [3:0] ch_tab  = 4'b0;
    logic [3:0] ih_tab  = 4'b0;

    initial begin
        bus.start = 1'b0; bus.pause = 1'b0; bus.correctHit = 1'b0; bus.incorrectHit = 1'b0;
        forever begin
            @(negedge clk);
            if (mode == 2) begin
                bus.start        = ($urandom_range(0, 19) == 0);
                bus.pause        = ($urandom_range(0, 3) == 0);
                bus.correctHit   = ($urandom_range(0, 1) == 1);
                bus.incorrectHit = ($urandom_range(0, 3) == 0);
            end else begin
                bus.start        = s_start;
                bus.pause        = s_pause;
                bus.correctHit   = (mode == 1) ? ch_tab[m_idx] : s_ch;
                bus.incorrectHit = (mode == 1) ? ih_tab[m_idx] : s_ih;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic pulse_start();
        s_start = 1'b1; cyc(1); s_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.done && n < 200) begin cyc(1); n++; end
        chk(name, int'(bus.done), 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_state"}, int'(bus.state), 0);
        chk({tag, "_arrow"}, int'(bus.arrow), 0);
        chk({tag, "_metro"}, int'(bus.metronome_clk), 0);
        chk({tag, "_score"}, int'(bus.score), 0);
        chk({tag, "_combo"}, int'(bus.combo), 0);
        chk({tag, "_maxc"}, int'(bus.max_combo), 0);
        chk({tag, "_misses"}, int'(bus.misses), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_addr"}, int'(bus.chart_addr), 0);
`ifdef BEAT_SCHED_LIVES_EN
        chk({tag, "_lives"}, int'(bus.lives), LV);
`endif
    endtask

    // ---------------- second instance: long all-hit chart ----------------
    bit b_go  = 0;
    bit b_fin = 0;

    initial begin
        int n;
        bus2.start = 1'b0; bus2.pause = 1'b0; bus2.correctHit = 1'b0; bus2.incorrectHit = 1'b0;
        wait (b_go);
        bus2.correctHit = 1'b1;
        @(negedge clk) bus2.start = 1'b1;
        @(negedge clk) bus2.start = 1'b0;
        n = 0;
        while (!bus2.done && n < 200) begin @(negedge clk); n++; end
        chk("long_done", int'(bus2.done), 1);
        chk("long_score", int'(bus2.score), 140);
        chk("long_combo", int'(bus2.combo), 12);
        chk("long_max", int'(bus2.max_combo), 12);
        chk("long_misses", int'(bus2.misses), 0);
        b_fin = 1;
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int first1, first2, hc, bc, pc, n;
        bit paused;

        cyc(3);
        chk_zero("reset");
        rst = 1'b0;
        cyc(2);

        // Beat timing, then a full all-hit game.
        mode = 0; s_ch = 1'b1; s_ih = 1'b0;
        pulse_start();
        chk("t1_fetch", int'(bus.state), P_FETCH);
        cyc(1);
        chk("t1_latch", int'(bus.state), P_LATCH);
        first1 = -1; first2 = -1; hc = 0;
        for (int i = 0; i < 40 && first2 < 0; i++) begin
            cyc(1);
            if (bus.state == 3'd3 && bus.arrow == 4'd1) begin
                if (first1 < 0) first1 = i;
                if (bus.metronome_clk) hc++;
            end
            if (bus.state == 3'd3 && bus.arrow == 4'd2) first2 = i;
        end
        chk("t1_first_arrow", first1, 0);
        chk("t1_window_len", hc, 4);
        chk("t1_beat_period", first2 - first1, 10);
        wait_done("t2_done_timeout");
        chk("t2_score", int'(bus.score), 30);
        chk("t2_combo", int'(bus.combo), 3);
        chk("t2_max", int'(bus.max_combo), 3);
        chk("t2_misses", int'(bus.misses), 0);
        chk("t2_arrow", int'(bus.arrow), 0);
        cyc(3);

        // Restart from DONE, then asynchronous reset mid-beat after one hit.
        pulse_start();
        chk("t5_restart_state", int'(bus.state), P_FETCH);
        chk("t5_restart_score", int'(bus.score), 0);
        chk("t5_restart_max", int'(bus.max_combo), 0);
        chk("t5_restart_addr", int'(bus.chart_addr), 0);
        n = 0;
        while (!(bus.state == 3'd3 && bus.arrow == 4'd2) && n < 40) begin cyc(1); n++; end
        chk("t5_reach_beat1", int'(bus.arrow), 2);
        chk("t5_pre_score", int'(bus.score), 10);
        cyc(2);
        #1 rst = 1'b1;
        #1 chk_zero("t5_async");
        cyc(2);
        rst = 1'b0;
        cyc(2);

        // Hit / double-press miss / blank / hit.
        mode = 1; ch_tab = 4'b1011; ih_tab = 4'b0010;
        pulse_start();
        wait_done("t3_done_timeout");
        chk("t3_score", int'(bus.score), 20);
        chk("t3_combo", int'(bus.combo), 1);
        chk("t3_max", int'(bus.max_combo), 1);
        chk("t3_misses", int'(bus.misses), 1);
        cyc(2);

        // Pause for 5 cycles at tick 2 of beat 0.
        mode = 0; s_ch = 1'b0; s_ih = 1'b0;
        pulse_start();
        bc = 0; hc = 0; pc = 0; paused = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (pc > 0) begin pc--; if (pc == 0) s_pause = 1'b0; end
            if (bus.state == 3'd3 && bus.arrow == 4'd1) begin
                bc++;
                if (bus.metronome_clk) hc++;
                if (bc == 3 && !paused) begin s_pause = 1'b1; pc = 5; paused = 1; end
            end
        end
        s_pause = 1'b0;
        chk("t4_beat_len", bc, 13);
        chk("t4_window_len", hc, 9);
        wait_done("t4_done_timeout");
        cyc(2);

`ifdef BEAT_SCHED_LIVES_EN
        // Out of lives: no presses, two lives.
        pulse_start();
        wait_done("t6_done_timeout");
        chk("t6_lives", int'(bus.lives), 0);
        chk("t6_misses", int'(bus.misses), 2);
        chk("t6_last_index", int'(bus.chart_addr), 1);
        cyc(2);
`endif

        // Random play checked cycle by cycle against the model.
        mode = 2;
        cyc(1500);
        mode = 0; s_start = 1'b0;
        cyc(2);

        b_go = 1;
        n = 0;
        while (!b_fin && n < 400) begin cyc(1); n++; end
        chk("long_finished", int'(b_fin), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/beat_scheduler.md
Name: beat_scheduler

Overview:
Sequences one play-through of a step chart for the arrow collision checker.
- Fetches one arrow code per beat from a synchronous chart ROM.
- Drives `arrow` and `metronome_clk` (the hit window) into the checker.
- Samples the checker's `correctHit`/`incorrectHit` at the end of each beat and maintains score, combo, max combo and miss count for the display logic.

Parameters:
- BEAT_TICKS, 50000000, clk cycles per beat in the BEAT state (must be >= 2).
- WINDOW_TICKS, 12500000, leading cycles of each beat with `metronome_clk` high (1 <= WINDOW_TICKS < BEAT_TICKS).
- CHART_LEN, 32, number of chart entries played (1..2^CHART_AW).
- CHART_AW, 5, chart address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; begins a game in IDLE or DONE
- pause  in  1  level; freezes beat timing while high
- chart_addr  out  CHART_AW  chart ROM address (registered beat index)
- chart_data  in  4  ROM data, valid 1 cycle after chart_addr changes
- correctHit  in  1  from collision checker
- incorrectHit  in  1  from collision checker
- arrow  out  4  current arrow code to checker (ARROW_NONE = 4'd0)
- metronome_clk  out  1  hit window to checker
- score  out  16  accumulated points
- combo  out  8  current consecutive-hit count
- max_combo  out  8  best combo this game
- misses  out  8  miss count
- done  out  1  high in DONE
- state  out  3  IDLE=0, FETCH=1, LATCH=2, BEAT=3, DONE=4

Behaviour:
- Reset (async, any time, including mid-beat): state IDLE; index, tick, arrow, metronome_clk, score, combo, max_combo, misses and done all 0.
- IDLE: on start=1, clear score/combo/max_combo/misses and index; go to FETCH.
- FETCH: chart_addr=index is stable; go to LATCH next cycle.
- LATCH: arrow <= chart_data; tick <= 0; go to BEAT.
- BEAT:
  - `metronome_clk` = (tick < WINDOW_TICKS). It is driven from a register, so it has no combinational path from tick.
  - tick increments each cycle while pause=0.
  - While pause=1, tick, metronome_clk and arrow all hold.
  - Evaluation happens in the cycle where tick == BEAT_TICKS-1 and pause=0. Stats update on the next edge, using the flag values sampled in that cycle.
- Beat period = BEAT_TICKS + 2 cycles. metronome_clk is low during FETCH, LATCH and DONE.
- Evaluation rules, arrow != NONE:
  - correctHit=1 and incorrectHit=0 is a hit.
  - Anything else (no press, or incorrectHit=1 including both flags high) is a miss.
- Evaluation rules, arrow == NONE:
  - incorrectHit=1 is a miss.
  - Otherwise nothing changes.
- Hit:
  - points = 15 if pre-update combo >= 8, else 10.
  - score += points, saturating at 16'hFFFF.
  - combo += 1, saturating at 255.
  - max_combo = max(max_combo, new combo).
- Miss: combo <= 0; misses += 1, saturating at 255.
- After evaluation:
  - If index == CHART_LEN-1: go to DONE.
  - Otherwise: index += 1 and go to FETCH.
- DONE: done=1, arrow=0, stats hold. start=1 restarts exactly as from IDLE.
- start is ignored in FETCH/LATCH/BEAT. pause is ignored outside BEAT.

Optional Feature:
Macro BEAT_SCHED_LIVES_EN.
- Defined:
  - Adds parameter LIVES (default 3, range 1..15) and output `lives` [3:0].
  - lives loads LIVES at reset and at every start.
  - Each miss decrements lives.
  - When a miss takes lives to 0, go to DONE after that evaluation, regardless of index.
- Undefined: no `lives` port or logic; the game always plays all CHART_LEN beats.

Test Plan:
Bench parameters: BEAT_TICKS=8, WINDOW_TICKS=4, CHART_LEN=4; chart = {1,2,0,4}.

1. Reset then start pulse -> FETCH/LATCH, then arrow=1, and metronome_clk high for exactly 4 cycles of an 8-cycle beat; next arrow appears 10 cycles after the first.
2. correctHit=1 held through every non-NONE beat, incorrectHit=0 -> final score=30, combo=3, max_combo=3, misses=0, done=1, arrow=0.
3. Beat 0 hit, beat 1 correctHit=incorrectHit=1, beat 3 hit -> score=20, combo=1, max_combo=1, misses=1.
4. pause=1 for 5 cycles at tick=2 of beat 0 -> metronome_clk stays high, and the beat lasts 13 cycles.
5. rst asserted mid-BEAT after one hit -> all outputs 0 immediately (asynchronous), state=IDLE. start after DONE -> stats cleared and index restarts at 0.
6. With BEAT_SCHED_LIVES_EN and LIVES=2, no presses -> DONE after the 2nd non-NONE miss (beat 1), lives=0, misses=2.
